// File: rtl/vga_vram_arbiter_if.sv
// Host request/acknowledge port and single-port RAM bus shared by the VRAM arbiter.
interface vga_vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic              hostReq;
  logic              hostWe;
  logic [AW-1:0]     hostAddr;
  logic [DW-1:0]     hostWdata;
  logic [DW/8-1:0]   hostBe;
  logic              hostAck;
  logic [DW-1:0]     hostRdata;
  logic              hostRvalid;

  logic              ramEn;
  logic              ramWe;
  logic [DW/8-1:0]   ramBe;
  logic [AW-1:0]     ramAddr;
  logic [DW-1:0]     ramWdata;
  logic [DW-1:0]     ramRdata;

  // master: host agent plus RAM model; slave: the arbiter
  modport master (
    output hostReq, hostWe, hostAddr, hostWdata, hostBe,
    input  hostAck, hostRdata, hostRvalid,
    input  ramEn, ramWe, ramBe, ramAddr, ramWdata,
    output ramRdata
  );

  modport slave (
    input  hostReq, hostWe, hostAddr, hostWdata, hostBe,
    output hostAck, hostRdata, hostRvalid,
    output ramEn, ramWe, ramBe, ramAddr, ramWdata,
    input  ramRdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// VRAM arbiter: fixed display prefetch slots, all other cycles to the host (ack same cycle, read data +2).
// Host backpressure is hostReq held until hostAck; a request colliding with a fetch slot waits one cycle.
module vga_vram_arbiter #(
  parameter int AW   = 16,
  parameter int DW   = 32,
  parameter int HDT  = 640,
  parameter int HTOT = 800,
  parameter int VDT  = 400,
  parameter int VTOT = 449
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [9:0]          pixelCnt,
  input  logic [8:0]          lineCnt,
  vga_vram_arbiter_if.slave   bus,
  output logic [7:0]          pixelData,
  output logic                pixelValid
);

  localparam logic [9:0] PRELOAD_PX    = 10'(HTOT - 4);
  localparam logic [9:0] LAST_FETCH_PX = 10'(HDT - 8);
  localparam logic [9:0] ACTIVE_PX     = 10'(HDT);
  localparam logic [8:0] ACTIVE_LN     = 9'(VDT);
  localparam logic [8:0] LAST_LN       = 9'(VTOT - 1);

  logic          synced;
  logic [AW-1:0] dispAddr;
  logic          tagDisp;
  logic          tagHost;
  logic [DW-1:0] holdReg;
  logic [DW-1:0] shiftReg;

  logic [8:0]    nextLine;
  logic          syncSet;
  logic          preloadSlot;
  logic          lineFetch;
  logic          slotF;
  logic          hostGrant;
  logic          pixelActive;

  assign nextLine    = (lineCnt == LAST_LN) ? 9'd0 : lineCnt + 9'd1;
  assign syncSet     = (lineCnt == LAST_LN) && (pixelCnt == PRELOAD_PX);
  assign preloadSlot = (pixelCnt == PRELOAD_PX) && (nextLine < ACTIVE_LN);
  assign lineFetch   = (lineCnt < ACTIVE_LN) && (pixelCnt[1:0] == 2'b00) &&
                       (pixelCnt <= LAST_FETCH_PX);

  // The preload slot that sets synced must already fetch address 0 itself.
  assign slotF       = reset && (synced || syncSet) && (preloadSlot || lineFetch);
  assign hostGrant   = reset && !slotF && bus.hostReq;
  assign pixelActive = synced && (lineCnt < ACTIVE_LN) && (pixelCnt < ACTIVE_PX);

  always_comb begin
    bus.ramEn    = slotF || hostGrant;
    bus.ramWe    = hostGrant && bus.hostWe;
    bus.ramBe    = (hostGrant && bus.hostWe) ? bus.hostBe : '0;
    bus.ramAddr  = slotF ? dispAddr : bus.hostAddr;
    bus.ramWdata = slotF ? '0 : bus.hostWdata;
    bus.hostAck  = hostGrant;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      synced         <= 1'b0;
      dispAddr       <= '0;
      tagDisp        <= 1'b0;
      tagHost        <= 1'b0;
      holdReg        <= '0;
      shiftReg       <= '0;
      bus.hostRdata  <= '0;
      bus.hostRvalid <= 1'b0;
      pixelData      <= 8'd0;
      pixelValid     <= 1'b0;
    end else begin
      if (syncSet)
        synced <= 1'b1;

      if ((lineCnt == ACTIVE_LN) && (pixelCnt == 10'd0))
        dispAddr <= '0;
      else if (slotF)
        dispAddr <= dispAddr + AW'(1);

      // Tag tells the next cycle who owns ramRdata.
      tagDisp        <= slotF;
      tagHost        <= hostGrant && !bus.hostWe;
      bus.hostRvalid <= tagHost;
      if (tagHost)
        bus.hostRdata <= bus.ramRdata;
      if (tagDisp)
        holdReg <= bus.ramRdata;

      if (pixelActive) begin
        pixelValid <= 1'b1;
        if (pixelCnt[1:0] == 2'b00) begin
          pixelData <= holdReg[7:0];
          shiftReg  <= holdReg >> 8;
        end else begin
          pixelData <= shiftReg[7:0];
          shiftReg  <= shiftReg >> 8;
        end
      end else begin
        pixelData  <= 8'd0;
        pixelValid <= 1'b0;
      end
    end
  end

endmodule
